key_event_gen: RTL and testbench



---
 rtl/key_event_gen_if.sv | 20 ++
 rtl/key_event_gen.sv | 121 ++++++++++++
 tb/tb_key_event_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
// Key event bundle: debounced level and repeat enable in, single-cycle key events out.
interface key_event_gen_if;
  logic db;
  logic repeat_en;
  logic press;
  logic rel;
  logic rep;
  logic evt;
  logic held;

  modport master (
    output db, repeat_en,
    input  press, rel, rep, evt, held
  );

  modport slave (
    input  db, repeat_en,
    output press, rel, rep, evt, held
  );
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced key level into press/release pulses plus typematic auto-repeat pulses.
module key_event_gen #(
  parameter int unsigned TICK_MAX     = 999999,
  parameter int unsigned PRE_W        = 20,
  parameter int unsigned DELAY_TICKS  = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned TCNT_W       = 8
) (
  input  logic            clk_in,
  input  logic            reset_n,
  key_event_gen_if.slave  key
);

  typedef enum logic [1:0] {IDLE, HELD, DELAY, REPEAT} state_t;

  state_t              state, state_d;
  logic                db_q;
  logic [PRE_W-1:0]    pre, pre_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic                rise, fall, tick, rep_d;
  logic                press_q, rel_q, rep_q, evt_q;

  assign rise = key.db & ~db_q;
  assign fall = ~key.db & db_q;
  assign tick = (pre == PRE_W'(TICK_MAX));

  // Next state; release wins over disable, disable wins over a repeat tick.
  always_comb begin
    state_d = state;
    pre_d   = '0;
    tcnt_d  = tcnt;
    rep_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (key.repeat_en) begin
            state_d = DELAY;
            tcnt_d  = '0;
          end else begin
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (fall) state_d = IDLE;
      end
      DELAY: begin
        if (fall) begin
          state_d = IDLE;
        end else if (!key.repeat_en) begin
          state_d = HELD;
        end else begin
          pre_d = tick ? '0 : pre + PRE_W'(1);
          if (tick) begin
            if (tcnt == TCNT_W'(DELAY_TICKS - 1)) begin
              rep_d   = 1'b1;
              state_d = REPEAT;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt + TCNT_W'(1);
            end
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
        end else if (!key.repeat_en) begin
          state_d = HELD;
        end else begin
          pre_d = tick ? '0 : pre + PRE_W'(1);
          if (tick) begin
            if (tcnt == TCNT_W'(REPEAT_TICKS - 1)) begin
              rep_d  = 1'b1;
              tcnt_d = '0;
            end else begin
              tcnt_d = tcnt + TCNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pre   <= '0;
      tcnt  <= '0;
      db_q  <= 1'b0;
    end else begin
      state <= state_d;
      pre   <= pre_d;
      tcnt  <= tcnt_d;
      db_q  <= key.db;
    end
  end

  // Event pulses, one cycle after the qualifying sample.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      press_q <= rise;
      rel_q   <= fall;
      rep_q   <= rep_d;
      evt_q   <= rise | rep_d;
    end
  end

  assign key.press = press_q;
  assign key.rel   = rel_q;
  assign key.rep   = rep_q;
  assign key.evt   = evt_q;
  assign key.held  = db_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with a short tick period (TICK_MAX=3, DELAY=3, REPEAT=2).
module tb_key_event_gen;

  logic clk_in;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  logic [63:0] mask_hold;
  logic [63:0] mask_first;

  key_event_gen_if kif ();

  key_event_gen #(
    .TICK_MAX    (3),
    .PRE_W       (4),
    .DELAY_TICKS (3),
    .REPEAT_TICKS(2),
    .TCNT_W      (8)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .key    (kif)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Output vector order: {press, rel, rep, evt, held}
  function automatic logic [4:0] outs();
    return {kif.press, kif.rel, kif.rep, kif.evt, kif.held};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("%s_idle%0d", name, k), 32'(outs()), 32'(5'b00000));
    end
  endtask

  // Raise db now (at a falling edge), keep it sampled high for len clocks, check every cycle.
  task automatic hold_seq(input string name, input int len, input int cycles,
                          input logic [63:0] rep_mask, input int en_at);
    logic [4:0] exp;
    kif.db = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      step();
      exp[4] = (k == 0);
      exp[3] = (k == len);
      exp[2] = rep_mask[k];
      exp[1] = exp[4] | exp[2];
      exp[0] = (k < len);
      check($sformatf("%s[P+%0d]", name, k), 32'(outs()), 32'(exp));
      if (k == len - 1) kif.db = 1'b0;
      if (k == en_at) kif.repeat_en = 1'b1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mask_hold  = '0;
    mask_hold[12] = 1'b1;
    mask_hold[20] = 1'b1;
    mask_hold[28] = 1'b1;
    mask_hold[36] = 1'b1;
    mask_first = '0;
    mask_first[12] = 1'b1;

    reset_n       = 1'b0;
    kif.db        = 1'b0;
    kif.repeat_en = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_outs", 32'(outs()), 32'(5'b00000));
    reset_n = 1'b1;
    idle("post_reset", 2);

    hold_seq("tap", 5, 8, 64'd0, -1);
    idle("tap", 2);

    hold_seq("hold", 40, 44, mask_hold, -1);
    idle("hold", 2);

    kif.repeat_en = 1'b0;
    hold_seq("norep", 40, 44, 64'd0, 10);
    idle("norep", 2);
    hold_seq("repress", 14, 16, mask_first, -1);
    idle("repress", 2);

    // Release lands on the tick that would have produced the P+20 repeat.
    hold_seq("collide", 20, 24, mask_first, -1);
    idle("collide", 2);
    hold_seq("restart", 14, 16, mask_first, -1);
    idle("restart", 2);

    // Reset while repeating, then leave db high across reset release.
    kif.db = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      step();
      check($sformatf("prerst[P+%0d]", k), 32'(outs()),
            32'({(k == 0), 1'b0, (k == 12), (k == 0) || (k == 12), 1'b1}));
    end
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'(5'b00000));
    @(negedge clk_in);
    check("rst_hold0", 32'(outs()), 32'(5'b00000));
    @(negedge clk_in);
    check("rst_hold1", 32'(outs()), 32'(5'b00000));
    reset_n = 1'b1;
    hold_seq("post_rst", 14, 16, mask_first, -1);
    idle("post_rst", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
